// File: rtl/muldiv_unit_p.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, MADD/MSUB accumulate,
// a restoring bit-serial divider, MTHI/MTLO writes and a pipeline-flush cancel.
module muldiv_unit_p #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             wr_en,
    input  logic             wr_hi,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rem, quo, dmag;

    logic             accept, last, commit;
    logic             start_sdiv, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] amag_in, bmag_in;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, acc, mul_res;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             sdiv, smul;

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start && !cancel;
    assign last   = ((state == MUL) && (count == MUL_LAST)) ||
                    ((state == DIV) && (count == DIV_LAST));
    assign commit = last && !cancel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (op[2:1] == 2'b01) ? DIV : MUL;
            MUL, DIV: if (cancel || last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The divider works on magnitudes, so signed operands are folded at capture.
    always_comb begin
        start_sdiv = (op[2:1] == 2'b01) && !op[0];
        a_neg_in   = start_sdiv && src_a[WIDTH-1];
        b_neg_in   = start_sdiv && src_b[WIDTH-1];
        amag_in    = a_neg_in ? (~src_a + WIDTH'(1)) : src_a;
        bmag_in    = b_neg_in ? (~src_b + WIDTH'(1)) : src_b;
    end

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dmag};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Commit values; the accumulate base is whatever HI/LO hold at the commit edge.
    always_comb begin
        smul    = !op_q[0];
        sdiv    = !op_q[0];
        ext_a   = {{WIDTH{smul & a_q[WIDTH-1]}}, a_q};
        ext_b   = {{WIDTH{smul & b_q[WIDTH-1]}}, b_q};
        product = ext_a * ext_b;
        acc     = {hi, lo};
        case (op_q[2:1])
            2'b10:   mul_res = acc + product;
            2'b11:   mul_res = acc - product;
            default: mul_res = product;
        endcase
        if (state == DIV) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_lo = (sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~quo_n + WIDTH'(1)) : quo_n;
                res_hi = (sdiv && a_q[WIDTH-1]) ? (~rem_n + WIDTH'(1)) : rem_n;
            end
        end else begin
            res_hi = mul_res[2*WIDTH-1:WIDTH];
            res_lo = mul_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem   <= '0;
            quo   <= '0;
            dmag  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
                count <= '0;
                rem   <= '0;
                quo   <= amag_in;
                dmag  <= bmag_in;
            end else if (state != IDLE) begin
                count <= count + CW'(1);
                if (state == DIV) begin
                    rem <= rem_n;
                    quo <= quo_n;
                end
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if ((state == IDLE) && wr_en && !accept) begin
                if (wr_hi) hi <= wr_data;
                else       lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Randomised and directed bench for muldiv_unit_p against an arithmetic reference model.
module tb_muldiv_unit_p;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 5;

   logic        clk = 1'b0;
   logic        reset, start, cancel, wr_en, wr_hi;
   logic [2:0]  op;
   logic [31:0] src_a, src_b, wr_data;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_acc;

   always #5 clk = ~clk;

   muldiv_unit_p #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .cancel(cancel),
      .wr_en(wr_en), .wr_hi(wr_hi), .wr_data(wr_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Reference: plain 64-bit arithmetic for products, native / and % for divides.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] base);
      longint      sa, sb, q, r;
      logic [63:0] p;
      if (o[2:1] == 2'b01) begin
         if (b == 32'h0) return {a, 32'hFFFF_FFFF};
         if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
         end
         return {a % b, a / b};
      end
      if (!o[0]) p = longint'($signed(a)) * longint'($signed(b));
      else       p = {32'h0, a} * {32'h0, b};
      if (!o[2])      return p;
      else if (!o[1]) return base + p;
      else            return base - p;
   endfunction

   function automatic int latency(input logic [2:0] o);
      return (o[2:1] == 2'b01) ? WIDTH : MUL_LAT;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // disturb: 0 none, 1 extra start during busy, 2 wr_en during busy, 3 wr_en with start
   task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int disturb);
      logic [63:0] expv;
      int          cycles;
      expv    = model(o, a, b, exp_acc);
      start   = 1'b1;
      op      = o;
      src_a   = a;
      src_b   = b;
      if (disturb == 3) begin
         wr_en = 1'b1; wr_hi = 1'b0; wr_data = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         if (cycles == 2 && disturb == 1) begin
            start = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd7;
         end
         if (cycles == 2 && disturb == 2) begin
            wr_en = 1'b1; wr_hi = cycles[0]; wr_data = 32'hCAFE_F00D;
         end
         tick();
         start = 1'b0;
         wr_en = 1'b0;
      end
      checks++;
      if (cycles !== latency(o)) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cycles, latency(o));
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s done: got %b, expected 1", name, done);
      end
      checks++;
      if ({hi, lo} !== expv) begin
         errors++;
         $display("[TB] FAIL %s hilo: got %h, expected %h", name, {hi, lo}, expv);
      end
      exp_acc = expv;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s after: done=%b busy=%b, expected 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cancel = 1'b0; wr_en = 1'b0; wr_hi = 1'b0;
      op = 3'b0; src_a = '0; src_b = '0; wr_data = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      exp_acc = 64'h0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset: busy=%b done=%b hi=%h lo=%h, expected all 0", busy, done, hi, lo);
      end
   endtask

   task automatic test_multiply();
      do_op("mult_neg3x7", 3'b000, 32'hFFFF_FFFD, 32'd7, 0);
      do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op("maddu_1x1", 3'b101, 32'd1, 32'd1, 0);
      checks++;
      if (lo !== 32'h2 || hi !== 32'hFFFF_FFFE) begin
         errors++;
         $display("[TB] FAIL maddu_literal: hi=%h lo=%h, expected fffffffe 00000002", hi, lo);
      end
      do_op("msub", 3'b110, 32'hFFFF_FFF0, 32'd3, 0);
      do_op("msubu", 3'b111, 32'h8000_0001, 32'h0000_0011, 0);
   endtask

   task automatic test_divide();
      do_op("divu_100_7", 3'b011, 32'd100, 32'd7, 0);
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("[TB] FAIL divu_literal: hi=%0d lo=%0d, expected 2 14", hi, lo);
      end
      do_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("div_5_0", 3'b010, 32'd5, 32'd0, 0);
      do_op("div_neg_by_0", 3'b010, 32'hFFFF_FF00, 32'd0, 0);
      do_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
         errors++;
         $display("[TB] FAIL div_min_literal: hi=%h lo=%h, expected 0 80000000", hi, lo);
      end
      do_op("divu_max", 3'b011, 32'hFFFF_FFFF, 32'd1, 0);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = ~32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         do_op("random", o, a, b, 0);
      end
   endtask

   task automatic test_back_to_back();
      do_op("start_while_busy", 3'b000, 32'd3, 32'd4, 1);
      do_op("madd_wr_busy", 3'b100, 32'd2, 32'd3, 2);
      do_op("start_with_wr", 3'b101, 32'd5, 32'd6, 3);
   endtask

   task automatic test_cancel();
      logic busy_seen;
      start = 1'b1; op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
      tick();
      start = 1'b0;
      repeat (9) tick();
      busy_seen = busy;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (busy_seen !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cancel_div: busy_before=%b busy=%b done=%b, expected 1 0 0", busy_seen, busy, done);
      end
      repeat (3) tick();
      checks++;
      if (done !== 1'b0 || {hi, lo} !== exp_acc) begin
         errors++;
         $display("[TB] FAIL cancel_div_hilo: done=%b hilo=%h, expected 0 %h", done, {hi, lo}, exp_acc);
      end

      start = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9;
      tick();
      start = 1'b0;
      repeat (4) tick();
      busy_seen = busy;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (busy_seen !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cancel_commit: busy_before=%b busy=%b done=%b, expected 1 0 0", busy_seen, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || {hi, lo} !== exp_acc) begin
         errors++;
         $display("[TB] FAIL cancel_commit_hilo: done=%b hilo=%h, expected 0 %h", done, {hi, lo}, exp_acc);
      end

      start = 1'b1; cancel = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd2;
      tick();
      start = 1'b0; cancel = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cancel_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_writes();
      wr_en = 1'b1; wr_hi = 1'b1; wr_data = 32'h1234;
      tick();
      wr_en = 1'b0;
      exp_acc[63:32] = 32'h1234;
      checks++;
      if (hi !== 32'h1234 || lo !== exp_acc[31:0]) begin
         errors++;
         $display("[TB] FAIL mthi: hi=%h lo=%h, expected 00001234 %h", hi, lo, exp_acc[31:0]);
      end
      wr_en = 1'b1; wr_hi = 1'b0; wr_data = 32'hA5A5_0001;
      tick();
      wr_en = 1'b0;
      exp_acc[31:0] = 32'hA5A5_0001;
      checks++;
      if ({hi, lo} !== exp_acc) begin
         errors++;
         $display("[TB] FAIL mtlo: hilo=%h, expected %h", {hi, lo}, exp_acc);
      end
      do_op("madd_after_mt", 3'b100, 32'hFFFF_FFFF, 32'd1, 0);
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = 3'b000; src_a = 32'd7; src_b = 32'd7;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, expected 0", hi, lo, busy, done);
      end
      tick();
      reset = 1'b0;
      repeat (6) tick();
      exp_acc = 64'h0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_after: busy=%b done=%b hilo=%h, expected idle 0", busy, done, {hi, lo});
      end
   endtask

   // Run every directed and random group, then report the tally.
   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_random();
      test_back_to_back();
      test_cancel();
      test_writes();
      test_reset_mid();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
